// File: rtl/loader_pkg.sv
// Shared types and constants for the framed byte-stream program loader.
package loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, RUN, ERROR} state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  // Largest legal word count for an instruction RAM of the given byte-address width.
  function automatic logic [31:0] max_words(input int addr_width);
    return 32'd1 << (addr_width - 2);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects little-endian bytes into a 32-bit word; flags the byte that completes it.
module byte_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic        word_complete
);

  logic [1:0]  byte_idx;
  logic [31:0] shreg;

  // Shifting right lands the first byte of a word in bits 7:0.
  assign word_next     = {byte_data, shreg[31:8]};
  assign word_complete = shift_en && (byte_idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (shift_en) begin
      byte_idx <= byte_idx + 2'd1;
      shreg    <= word_next;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Framed program loader: header word count, N little-endian words, XOR checksum.
// Holds the CPU halted until the whole image is accepted and verified.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  instruction_write,
  output logic [31:0]           instruction_out,
  output logic                  debug_enable,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  localparam int              WL        = ADDR_WIDTH - 1;
  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]     MAX_WORDS = max_words(ADDR_WIDTH);

  state_t          state;
  logic [WL-1:0]   n_words;
  logic [7:0]      xor_acc;
  logic [TW-1:0]   tmo_cnt;
  logic            hs;
  logic            restart;
  logic [31:0]     word_next;
  logic            word_complete;

  assign byte_ready = (state == HDR) || (state == DATA) || (state == CSUM);
  assign hs         = byte_valid && byte_ready;
  assign restart    = start && ((state == IDLE) || (state == RUN) || (state == ERROR));

  byte_word_assembler u_asm (
    .clk           (clk),
    .rst           (rst),
    .clear         (restart),
    .shift_en      (hs),
    .byte_data     (byte_data),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      n_words           <= '0;
      xor_acc           <= '0;
      tmo_cnt           <= '0;
      instruction_write <= 1'b0;
      instruction_out   <= '0;
      words_loaded      <= '0;
      debug_enable      <= 1'b0;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
    end else begin
      instruction_write <= 1'b0;
      // The strobe lands one cycle after the completing byte, even if the FSM has moved to CSUM.
      if (state == DATA && word_complete) begin
        instruction_write <= 1'b1;
        instruction_out   <= word_next;
        words_loaded      <= words_loaded + 1'b1;
      end
      if (byte_ready) tmo_cnt <= hs ? '0 : tmo_cnt + 1'b1;

      case (state)
        IDLE, RUN, ERROR: begin
          if (start) begin
            state        <= HDR;
            words_loaded <= '0;
            xor_acc      <= '0;
            tmo_cnt      <= '0;
            debug_enable <= 1'b0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
          end
        end
        HDR: begin
          if (word_complete) begin
            if (word_next == 32'd0 || word_next > MAX_WORDS) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else begin
              n_words <= word_next[WL-1:0];
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (hs) xor_acc <= xor_acc ^ byte_data;
          if (word_complete && (words_loaded + 1'b1 == n_words)) state <= CSUM;
        end
        CSUM: begin
          if (hs) begin
            if (byte_data == xor_acc) begin
              state        <= RUN;
              debug_enable <= 1'b1;
              load_done    <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Idle stream for too long while a frame is open aborts the load.
      if (byte_ready && !hs && tmo_cnt == TMO_LAST) begin
        state      <= ERROR;
        load_error <= 1'b1;
        tmo_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: framing, checksum, header bounds, throughput, timeout, reset.
module tb_instruction_loader;

  localparam int AW  = 16;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        instruction_write;
  logic [31:0] instruction_out;
  logic        debug_enable;
  logic        load_done;
  logic        load_error;
  logic [AW-2:0] words_loaded;

  always #5 clk = ~clk;

  instruction_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .instruction_write (instruction_write),
    .instruction_out   (instruction_out),
    .debug_enable      (debug_enable),
    .load_done         (load_done),
    .load_error        (load_error),
    .words_loaded      (words_loaded)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          run_cyc = 0;
  logic [31:0] wlog [64];
  int          tlog [64];
  int          s0, r0, k;
  logic [7:0]  f2[$], f2bad[$], f3[$], f6[$], f9[$], h0[$], h4001[$], h4000[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (instruction_write) begin
      if (strobes < 64) begin
        wlog[strobes] = instruction_out;
        tlog[strobes] = cyc;
      end
      strobes++;
    end
    if (load_done) run_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a byte and return at the negedge after its handshake; byte_valid stays high.
  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_ready", {31'd0, byte_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int maxgap);
    foreach (f[i]) begin
      send(f[i]);
      if (maxgap > 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_write"}, {31'd0, instruction_write}, 32'd0);
    check({tag, "_out"},   instruction_out, 32'd0);
    check({tag, "_dbg"},   {31'd0, debug_enable}, 32'd0);
    check({tag, "_done"},  {31'd0, load_done}, 32'd0);
    check({tag, "_err"},   {31'd0, load_error}, 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Payload XOR: 13^05^10^00^93^05^20^00 = B0; adding 13^06^30^00 gives 95.
    f2    = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    f2bad = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00, 8'h4F};
    f3    = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00, 8'h13, 8'h06, 8'h30, 8'h00, 8'h95};
    f6    = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05};
    f9    = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
    h0    = '{8'h00, 8'h00, 8'h00, 8'h00};
    h4001 = '{8'h01, 8'h40, 8'h00, 8'h00};
    h4000 = '{8'h00, 8'h40, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Normal load, back-to-back bytes.
    s0 = strobes;
    pulse_start();
    check("hdr_ready", {31'd0, byte_ready}, 32'd1);
    send_frame(f2, 0);
    check("n2_done",   {31'd0, load_done}, 32'd1);
    check("n2_dbg",    {31'd0, debug_enable}, 32'd1);
    check("n2_err",    {31'd0, load_error}, 32'd0);
    check("n2_words",  32'(words_loaded), 32'd2);
    check("n2_strobes", 32'(strobes - s0), 32'd2);
    check("n2_w0",     wlog[s0], 32'h0010_0513);
    check("n2_w1",     wlog[s0+1], 32'h0020_0593);

    // Restart from RUN drops the run enable at once and accepts a new header.
    pulse_start();
    check("rs_dbg",   {31'd0, debug_enable}, 32'd0);
    check("rs_done",  {31'd0, load_done}, 32'd0);
    check("rs_ready", {31'd0, byte_ready}, 32'd1);
    check("rs_words", 32'(words_loaded), 32'd0);

    // Bad checksum.
    s0 = strobes;
    r0 = run_cyc;
    send_frame(f2bad, 0);
    check("bc_err",     {31'd0, load_error}, 32'd1);
    check("bc_dbg",     {31'd0, debug_enable}, 32'd0);
    check("bc_strobes", 32'(strobes - s0), 32'd2);
    check("bc_run",     32'(run_cyc - r0), 32'd0);

    // Header bounds.
    s0 = strobes;
    pulse_start();
    send_frame(h0, 0);
    check("n0_err",     {31'd0, load_error}, 32'd1);
    check("n0_ready",   {31'd0, byte_ready}, 32'd0);
    check("n0_strobes", 32'(strobes - s0), 32'd0);
    pulse_start();
    send_frame(h4001, 0);
    check("n4001_err",  {31'd0, load_error}, 32'd1);
    pulse_start();
    send_frame(h4000, 0);
    repeat (5) @(negedge clk);
    check("n4000_err",   {31'd0, load_error}, 32'd0);
    check("n4000_ready", {31'd0, byte_ready}, 32'd1);
    repeat (50) @(negedge clk);
    check("n4000_tmo",   {31'd0, load_error}, 32'd1);

    // Back-to-back N=3: one strobe every 4 cycles.
    pulse_start();
    s0 = strobes;
    send_frame(f3, 0);
    check("b2b_done",    {31'd0, load_done}, 32'd1);
    check("b2b_strobes", 32'(strobes - s0), 32'd3);
    check("b2b_gap01",   32'(tlog[s0+1] - tlog[s0]), 32'd4);
    check("b2b_gap12",   32'(tlog[s0+2] - tlog[s0+1]), 32'd4);
    check("b2b_w2",      wlog[s0+2], 32'h0030_0613);

    // Throttled stream with random gaps: identical words, same order.
    pulse_start();
    s0 = strobes;
    send_frame(f3, 5);
    check("thr_done",    {31'd0, load_done}, 32'd1);
    check("thr_strobes", 32'(strobes - s0), 32'd3);
    check("thr_w0",      wlog[s0], 32'h0010_0513);
    check("thr_w1",      wlog[s0+1], 32'h0020_0593);
    check("thr_w2",      wlog[s0+2], 32'h0030_0613);

    // Timeout after 6 payload bytes.
    pulse_start();
    send_frame(f6, 0);
    k = 0;
    while (!load_error && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", 32'(k), 32'd50);
    check("tmo_words",  32'(words_loaded), 32'd1);
    check("tmo_dbg",    {31'd0, debug_enable}, 32'd0);

    // Reset mid-DATA: outputs clear and the stream is no longer accepted.
    pulse_start();
    s0 = strobes;
    send_frame(f9, 0);
    check("rst_pre_strobes", 32'(strobes - s0), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rstmid");
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (12) @(negedge clk);
    byte_valid = 1'b0;
    check("rst_post_strobes", 32'(strobes - s0), 32'd1);
    check("rst_post_ready",   {31'd0, byte_ready}, 32'd0);

    // Reset wins over a coincident start.
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    check("rst_start_ready", {31'd0, byte_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
